// File: rtl/pred_pkg.sv
// Constants shared by the branch predictor and the fetch/execute stages that carry
// its index and history snapshots.
package pred_pkg;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned DEF_CTR_W  = 2;
  localparam int unsigned DEF_IDX_W  = 8;
  localparam int unsigned DEF_HIST_W = 8;

  // Weakly-not-taken value: the counter point just below the taken threshold.
  function automatic int unsigned ctr_init(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/pht_counter.sv
// Single saturating pattern-history counter. It never wraps, and reset has priority
// over any pending increment or decrement.
module pht_counter
  import pred_pkg::*;
#(
  parameter int unsigned CTR_W = DEF_CTR_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] ctr
);

  localparam logic [CTR_W-1:0] CtrMax  = '1;
  localparam logic [CTR_W-1:0] CtrInit = CTR_W'(ctr_init(CTR_W));

  logic [CTR_W-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (inc && (ctr_q != CtrMax)) begin
      ctr_d = ctr_q + CTR_W'(1);
    end else if (dec && (ctr_q != '0)) begin
      ctr_d = ctr_q - CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q <= CtrInit;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr = ctr_q;

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: a PHT indexed by PC XOR a speculative global history.
// Define GSHARE_HASH_EN for gshare; without it the block is a plain bimodal table.
module gshare_predictor
  import pred_pkg::*;
#(
  parameter int unsigned CTR_W  = DEF_CTR_W,
  parameter int unsigned IDX_W  = DEF_IDX_W,
  parameter int unsigned HIST_W = DEF_HIST_W,
  parameter int unsigned PC_LSB = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  output logic [HIST_W-1:0] pred_hist,
  input  logic              update_valid,
  input  logic [IDX_W-1:0]  update_idx,
  input  logic [HIST_W-1:0] update_hist,
  input  logic              update_taken,
  input  logic              update_mispredict
);

  localparam int unsigned Entries = 1 << IDX_W;

  logic [CTR_W-1:0]  ctr [Entries];
  logic [IDX_W-1:0]  pc_idx;
  logic [IDX_W-1:0]  lookup_idx;
  logic [CTR_W-1:0]  pred_ctr;
  logic [HIST_W-1:0] ghr;

  assign pc_idx = lookup_pc[PC_LSB +: IDX_W];

`ifdef GSHARE_HASH_EN
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic [HIST_W-1:0] ghr_shift, ghr_restore;
  logic              unused_hash;

  if (HIST_W == 1) begin : g_hist_one
    assign ghr_shift   = pred_taken;
    assign ghr_restore = update_taken;
  end else begin : g_hist_wide
    assign ghr_shift   = {ghr_q[HIST_W-2:0], pred_taken};
    assign ghr_restore = {update_hist[HIST_W-2:0], update_taken};
  end

  // Mispredict recovery wins over the speculative shift of a same-cycle lookup.
  always_comb begin
    ghr_d = ghr_q;
    if (update_valid && update_mispredict) begin
      ghr_d = ghr_restore;
    end else if (lookup_valid) begin
      ghr_d = ghr_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ghr         = ghr_q;
  assign lookup_idx  = pc_idx ^ IDX_W'(ghr_q);
  assign unused_hash = ^{lookup_pc, update_hist, pred_ctr};
`else
  logic unused_bimodal;

  assign ghr            = '0;
  assign lookup_idx     = pc_idx;
  assign unused_bimodal = ^{lookup_valid, lookup_pc, update_hist, update_mispredict, pred_ctr};
`endif

  for (genvar i = 0; i < Entries; i++) begin : g_pht
    logic hit;

    assign hit = update_valid && (update_idx == IDX_W'(i));

    pht_counter #(
      .CTR_W(CTR_W)
    ) u_ctr (
      .clk  (clk),
      .reset(reset),
      .inc  (hit && update_taken),
      .dec  (hit && !update_taken),
      .ctr  (ctr[i])
    );
  end

  // Read straight from the registered table: a same-cycle update is not bypassed.
  assign pred_ctr   = ctr[lookup_idx];
  assign pred_taken = pred_ctr[CTR_W-1];
  assign pred_idx   = lookup_idx;
  assign pred_hist  = ghr;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor; expectations follow GSHARE_HASH_EN.
module tb_gshare_predictor;

  localparam int unsigned IdxW  = 8;
  localparam int unsigned HistW = 8;
`ifdef GSHARE_HASH_EN
  localparam bit HashEn = 1'b1;
`else
  localparam bit HashEn = 1'b0;
`endif

  // Per-step outcome and expected prediction at idx 5, bit i = step i.
  localparam logic [10:0] SatTaken = 11'b11000001111;
  localparam logic [10:0] SatPred  = 11'b10000011111;

  logic             clk = 1'b0;
  logic             reset;
  logic             lookup_valid;
  logic [31:0]      lookup_pc;
  logic             pred_taken;
  logic [IdxW-1:0]  pred_idx;
  logic [HistW-1:0] pred_hist;
  logic             update_valid;
  logic [IdxW-1:0]  update_idx;
  logic [HistW-1:0] update_hist;
  logic             update_taken;
  logic             update_mispredict;

  int checks = 0;
  int errors = 0;

  gshare_predictor #(
    .CTR_W (2),
    .IDX_W (IdxW),
    .HIST_W(HistW),
    .PC_LSB(2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .pred_taken       (pred_taken),
    .pred_idx         (pred_idx),
    .pred_hist        (pred_hist),
    .update_valid     (update_valid),
    .update_idx       (update_idx),
    .update_hist      (update_hist),
    .update_taken     (update_taken),
    .update_mispredict(update_mispredict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid      = 1'b0;
    update_valid      = 1'b0;
    update_mispredict = 1'b0;
    update_taken      = 1'b0;
    update_hist       = '0;
    update_idx        = '0;
  endtask

  task automatic upd(input logic [IdxW-1:0] idx, input logic taken);
    update_valid      = 1'b1;
    update_idx        = idx;
    update_taken      = taken;
    update_mispredict = 1'b0;
    tick();
    update_valid = 1'b0;
  endtask

  // Combinational look without a clock edge, so the history is not shifted.
  task automatic peek(input string tag, input logic [31:0] pc, input logic exp_taken,
                      input logic [IdxW-1:0] exp_idx, input logic [HistW-1:0] exp_hist);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    #1;
    check({tag, "_taken"}, 32'(pred_taken), 32'(exp_taken));
    check({tag, "_idx"}, 32'(pred_idx), 32'(exp_idx));
    check({tag, "_hist"}, 32'(pred_hist), 32'(exp_hist));
    lookup_valid = 1'b0;
  endtask

  task automatic spec_lookup(input logic [31:0] pc, input logic [IdxW-1:0] exp_idx,
                             input logic [HistW-1:0] exp_hist);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    #1;
    check("spec_taken", 32'(pred_taken), 32'd1);
    check("spec_idx", 32'(pred_idx), 32'(exp_idx));
    check("spec_hist", 32'(pred_hist), 32'(exp_hist));
    tick();
    lookup_valid = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    lookup_pc = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    peek("post_reset", 32'h100, 1'b0, 8'h40, 8'h00);

    // Saturation at idx 5 (pc 0x14, history still zero).
    for (int i = 0; i < 11; i++) begin
      upd(8'd5, SatTaken[i]);
      peek("sat", 32'h14, SatPred[i], 8'd5, 8'h00);
    end

    // Train idx 4 and 6 taken so every speculative lookup below predicts taken.
    upd(8'd4, 1'b1);
    upd(8'd4, 1'b1);
    upd(8'd6, 1'b1);
    upd(8'd6, 1'b1);
    spec_lookup(32'h14, 8'd5, 8'h00);
    spec_lookup(32'h10, HashEn ? 8'd5 : 8'd4, HashEn ? 8'h01 : 8'h00);
    spec_lookup(32'h18, HashEn ? 8'd5 : 8'd6, HashEn ? 8'h03 : 8'h00);
    peek("hist3", 32'h100, 1'b0, HashEn ? 8'h47 : 8'h40, HashEn ? 8'h07 : 8'h00);

    // Recovery and a same-cycle lookup: the restore must win.
    lookup_valid      = 1'b1;
    lookup_pc         = 32'h100;
    update_valid      = 1'b1;
    update_idx        = 8'h20;
    update_taken      = 1'b0;
    update_mispredict = 1'b1;
    update_hist       = 8'h0F;
    tick();
    idle();
    peek("recover", 32'h0, 1'b0, HashEn ? 8'h1E : 8'h00, HashEn ? 8'h1E : 8'h00);

    // A correctly predicted update must not touch the history.
    update_valid      = 1'b1;
    update_idx        = 8'h21;
    update_taken      = 1'b1;
    update_mispredict = 1'b0;
    update_hist       = 8'hAA;
    tick();
    idle();
    peek("no_mp", 32'h0, 1'b0, HashEn ? 8'h1E : 8'h00, HashEn ? 8'h1E : 8'h00);

    // Same-index collision at idx 9: the lookup sees the pre-update counter.
    lookup_valid = 1'b1;
    lookup_pc    = HashEn ? 32'h5C : 32'h24;
    update_valid = 1'b1;
    update_idx   = 8'd9;
    update_taken = 1'b1;
    #1;
    check("coll_now_taken", 32'(pred_taken), 32'd0);
    check("coll_now_idx", 32'(pred_idx), 32'd9);
    tick();
    idle();
    peek("coll_next", HashEn ? 32'hD4 : 32'h24, 1'b1, 8'd9, HashEn ? 8'h3C : 8'h00);

    // Reset with an update and a lookup in flight.
    reset        = 1'b1;
    lookup_valid = 1'b1;
    lookup_pc    = 32'h100;
    update_valid = 1'b1;
    update_idx   = 8'd9;
    update_taken = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    peek("rst_idx9", 32'h24, 1'b0, 8'd9, 8'h00);
    peek("rst_idx5", 32'h14, 1'b0, 8'd5, 8'h00);
    peek("rst_idx4", 32'h10, 1'b0, 8'd4, 8'h00);
    peek("rst_pc100", 32'h100, 1'b0, 8'h40, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 The block SHALL have parameter CTR_W, default 2, giving the counter width in bits (legal range 1..4).
REQ-002 The block SHALL have parameter IDX_W, default 8, giving the pattern-history-table index width (2^IDX_W entries).
REQ-003 The block SHALL have parameter HIST_W, default 8, giving the global-history width (legal range 1..IDX_W).
REQ-004 The block SHALL have parameter PC_LSB, default 2, giving the lowest PC bit used for indexing.
REQ-005 The block SHALL have port clk, input, 1 bit, the clock.
REQ-006 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-007 The block SHALL have port lookup_valid, input, 1 bit, a fetch-stage lookup request.
REQ-008 The block SHALL have port lookup_pc, input, 32 bits, the PC of the lookup.
REQ-009 The block SHALL have port pred_taken, output, 1 bit, the taken prediction.
REQ-010 The block SHALL have port pred_idx, output, IDX_W bits, the table index used, which the pipeline carries to resolve.
REQ-011 The block SHALL have port pred_hist, output, HIST_W bits, the history snapshot taken before this lookup's shift.
REQ-012 The block SHALL have port update_valid, input, 1 bit, a resolved-branch update.
REQ-013 The block SHALL have ports update_idx (IDX_W), update_hist (HIST_W), update_taken (1) and update_mispredict (1), all inputs, giving the resolved branch's carried index, carried history, actual outcome and mispredict flag.

Function
REQ-014 Lookup SHALL be combinational from registered state: pred_idx, pred_taken and pred_hist are valid in the same cycle as lookup_pc, with zero-cycle latency.
REQ-015 pred_taken SHALL equal the MSB of the counter at pred_idx, and outputs are don't-care when lookup_valid=0.
REQ-016 On update_valid, counter[update_idx] SHALL increment if update_taken and the counter is below 2^CTR_W-1, decrement if !update_taken and the counter is above 0, and otherwise hold (saturating, no wrap), effective at the next edge.
REQ-017 A same-cycle lookup and update to the same index SHALL return the pre-update counter (no bypass).
REQ-018 The GHR SHALL shift speculatively on lookup_valid: ghr <= {ghr[HIST_W-2:0], pred_taken}; when HIST_W=1, ghr <= pred_taken.
REQ-019 On update_valid && update_mispredict, the GHR SHALL be restored to {update_hist[HIST_W-2:0], update_taken}, and this recovery SHALL take priority over a same-cycle lookup shift.
REQ-020 An update with update_mispredict=0 SHALL leave the GHR unaffected.
REQ-021 Updates SHALL be accepted every cycle with no backpressure and no internal state machine beyond the GHR and counters.

Reset
REQ-022 On reset, every counter SHALL load 2^(CTR_W-1)-1 (weakly not-taken), so pred_taken=0 after reset.
REQ-023 On reset, the GHR SHALL load 0, so pred_hist=0 after reset.
REQ-024 Reset SHALL override any same-cycle lookup or update, and an update in flight when reset asserts is discarded.

Configuration
REQ-025 When macro GSHARE_HASH_EN is defined, the index SHALL be lookup_pc[PC_LSB+IDX_W-1:PC_LSB] XOR the GHR zero-extended to IDX_W.
REQ-026 When GSHARE_HASH_EN is undefined, the block SHALL behave as bimodal: the index is the PC bits alone, the GHR is held at 0, pred_hist=0, and update_hist and update_mispredict are ignored.

Structure
REQ-027 Package pred_pkg SHALL hold the PC_W=32 constant and the default CTR_W, IDX_W and HIST_W constants shared with the fetch and execute stages.
REQ-028 Each table entry SHALL be one instance of sub-module pht_counter (parameter CTR_W; ports clk, reset, inc, dec, ctr), generated 2^IDX_W times.

Verification
REQ-029 The bench SHALL cover post-reset lookup: reset, then lookup at pc=0x100 -> pred_taken=0, pred_hist=0, pred_idx=0x40.
REQ-030 The bench SHALL cover saturation with CTR_W=2: three taken updates to idx 5 -> counter 3, a fourth taken update leaves it at 3, and four not-taken updates -> 0, a fifth leaves it at 0.
REQ-031 The bench SHALL cover speculative history: three lookups each predicting taken from ghr=0 -> ghr=0x07, and with GSHARE_HASH_EN, a lookup at pc=0x100 then gives pred_idx=0x47.
REQ-032 The bench SHALL cover recovery priority: a same-cycle lookup plus mispredict update with update_hist=0x0F and update_taken=0 -> ghr=0x1E next cycle, ignoring the lookup shift.
REQ-033 The bench SHALL cover a same-index collision: counter at idx 9 is 1, and a same-cycle lookup and taken update at idx 9 -> pred_taken=0 this cycle and 1 the next cycle.
REQ-034 The bench SHALL cover reset mid-run: reset asserted together with update_valid -> all counters return to 1 and ghr=0, and the update is discarded.
